// File: rtl/serializer_pkg.sv
// Shared types and constants for the bitstream serializer.
//   state_t     : serializer FSM states
//   DATA_W_DEF  : default frame width in bits
//   DIV_W_DEF   : default width of the bit-period divider
//   CNT_W       : bit counter width for the default frame width
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF  = 8;

  // Bit counter width for a frame of n bits; never below 1 so the
  // counter stays a legal vector for tiny frames.
  function automatic int bit_cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = bit_cnt_width(DATA_W_DEF);

endpackage

// File: rtl/bitstream_serializer_if.sv
// Parallel load handshake between a word producer and the serializer.
//   load_data  : word to serialize
//   load_valid : load_data is valid
//   load_ready : serializer hold register is empty
// master = producer side, slave = serializer side.
interface bitstream_serializer_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              load_ready;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/bit_period_timer.sv
// Reloadable down-counter used to pace serial bits / strobes.
//   clk        : system clock
//   rst        : synchronous active-high reset (count -> 0)
//   reload     : load reload_val into the counter this edge
//   reload_val : period minus one
//   tick       : count is 0; the period ends at this edge
// The counter parks at 0 until the next reload.
module bit_period_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= reload_val;
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/bitstream_serializer.sv
// Parallel-to-serial feeder with one word of buffering ahead of the
// word being shifted, and a programmable number of clocks per bit.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   lif        : load handshake (slave side), load_ready = ~hold_valid
//   div        : bit period minus one, sampled at each bit start
//   msb_first  : bit order, latched at each frame start
//   bit_out    : current serial bit, 0 when idle
//   bit_valid  : strobe in the first cycle of each new bit
//   busy       : a word is held or a frame is shifting
//   frame_done : strobe in the cycle after a frame's last bit period
//
// state | meaning
// IDLE  | no frame shifting; bit_out held at 0
// SHIFT | shift_reg being presented one bit per div+1 clocks
module bitstream_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  bitstream_serializer_if.slave lif,
  input  logic [DIV_W-1:0]      div,
  input  logic                  msb_first,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BIT_CNT_W = bit_cnt_width(DATA_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_t               state;
  logic [DATA_W-1:0]    hold;
  logic                 hold_valid;
  logic [DATA_W-1:0]    shift_reg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 msb_lat;
  logic                 bit_out_r;
  logic                 bit_valid_r;
  logic                 frame_done_r;

  logic tick;
  logic load_fire;
  logic frame_end;
  logic advance;
  logic start_frame;
  logic first_bit;
  logic next_bit;

  assign load_fire   = lif.load_valid && !hold_valid;
  assign frame_end   = (state == SHIFT) && tick && (bit_cnt == LAST_BIT);
  assign advance     = (state == SHIFT) && tick && (bit_cnt != LAST_BIT);
  // A held word starts either from IDLE or back-to-back at a frame end.
  assign start_frame = hold_valid && ((state == IDLE) || frame_end);
  assign first_bit   = msb_first ? hold[DATA_W-1] : hold[0];
  // Bit that becomes visible after the current one is shifted out.
  assign next_bit    = msb_lat ? shift_reg[DATA_W-2] : shift_reg[1];

  bit_period_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .reload    (start_frame || advance),
    .reload_val(div),
    .tick      (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold         <= '0;
      hold_valid   <= 1'b0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      msb_lat      <= 1'b0;
      bit_out_r    <= 1'b0;
      bit_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      bit_valid_r  <= 1'b0;
      frame_done_r <= frame_end;

      // load_fire needs hold empty and start_frame needs hold full, so
      // the two never touch hold_valid in the same edge.
      if (load_fire) begin
        hold       <= lif.load_data;
        hold_valid <= 1'b1;
      end

      if (start_frame) begin
        state       <= SHIFT;
        shift_reg   <= hold;
        hold_valid  <= 1'b0;
        msb_lat     <= msb_first;
        bit_cnt     <= '0;
        bit_out_r   <= first_bit;
        bit_valid_r <= 1'b1;
      end else if (frame_end) begin
        state     <= IDLE;
        shift_reg <= '0;
        bit_cnt   <= '0;
        bit_out_r <= 1'b0;
      end else if (advance) begin
        shift_reg   <= msb_lat ? (shift_reg << 1) : (shift_reg >> 1);
        bit_cnt     <= bit_cnt + BIT_CNT_W'(1);
        bit_out_r   <= next_bit;
        bit_valid_r <= 1'b1;
      end
    end
  end

  assign lif.load_ready = ~hold_valid;
  assign busy           = hold_valid || (state == SHIFT);
  assign bit_out        = bit_out_r;
  assign bit_valid      = bit_valid_r;
  assign frame_done     = frame_done_r;

endmodule

// File: tb/tb_bitstream_serializer.sv
// Directed self-checking bench for bitstream_serializer.
module tb_bitstream_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] div;
  logic       msb_first;
  logic       bit_out;
  logic       bit_valid;
  logic       busy;
  logic       frame_done;

  int n_chk;
  int n_err;

  bitstream_serializer_if #(.DATA_W(8)) lif ();

  bitstream_serializer #(
    .DATA_W(8),
    .DIV_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lif       (lif),
    .div       (div),
    .msb_first (msb_first),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream Mealy 11011 non-overlapping detector model.
  logic [4:0] det_hist;
  logic [4:0] h_next;
  int         det_len;
  int         det_matches;

  always @(negedge clk) begin
    if (rst) begin
      det_hist    <= '0;
      det_len     <= 0;
      det_matches <= 0;
    end else if (bit_valid) begin
      h_next = {det_hist[3:0], bit_out};
      if (det_len >= 4 && h_next == 5'b11011) begin
        det_matches <= det_matches + 1;
        det_hist    <= '0;
        det_len     <= 0;
      end else begin
        det_hist <= h_next;
        det_len  <= det_len + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp8;
    logic [15:0] exp16;
    logic [7:0]  w1;
    logic [7:0]  w2;
    int          m0;
    int          j;
    int          nb;
    int          blen;
    int          seen;

    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    div = 8'd0;
    msb_first = 1'b1;
    lif.load_valid = 1'b0;
    lif.load_data  = 8'h00;

    // Reset state
    step();
    step();
    chk("rst_bit_out", bit_out, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_load_ready", lif.load_ready, 1);
    rst = 1'b0;
    step();
    chk("idle_load_ready", lif.load_ready, 1);

    // 0xDB, MSB first, div=0
    m0 = det_matches;
    exp8 = 8'b11011011;
    lif.load_data = 8'hDB;
    lif.load_valid = 1'b1;
    step();
    chk("db_ready_after_hs", lif.load_ready, 0);
    chk("db_no_bit_yet", bit_valid, 0);
    chk("db_busy", busy, 1);
    lif.load_valid = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("db_bit", bit_out, exp8[7-i]);
      chk("db_valid", bit_valid, 1);
      chk("db_fd_low", frame_done, 0);
      step();
    end
    chk("db_frame_done", frame_done, 1);
    chk("db_end_valid", bit_valid, 0);
    chk("db_end_bit", bit_out, 0);
    chk("db_end_busy", busy, 0);
    step();
    chk("db_fd_one_cycle", frame_done, 0);
    chk("db_detector", det_matches - m0, 1);

    // 0xA5, div=3, div changed to 0 during bit 4
    exp8 = 8'b10100101;
    div = 8'd3;
    lif.load_data = 8'hA5;
    lif.load_valid = 1'b1;
    step();
    lif.load_valid = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      blen = (i <= 4) ? 4 : 1;
      for (int c = 0; c < blen; c++) begin
        chk("a5_bit", bit_out, exp8[7-i]);
        chk("a5_valid", bit_valid, (c == 0) ? 1 : 0);
        chk("a5_fd_low", frame_done, 0);
        if (i == 4 && c == 1) div = 8'd0;
        step();
      end
    end
    chk("a5_frame_done", frame_done, 1);
    chk("a5_end_busy", busy, 0);
    step();

    // Back-to-back 0xB6, 0x6D with load_valid held high
    exp16 = 16'b1011011001101101;
    lif.load_data = 8'hB6;
    lif.load_valid = 1'b1;
    step();
    chk("b2b_ready_first", lif.load_ready, 0);
    lif.load_data = 8'h6D;
    step();
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      chk("b2b_bit", bit_out, exp16[15-k]);
      chk("b2b_valid", bit_valid, 1);
      chk("b2b_fd", frame_done, (k == 8) ? 1 : 0);
      chk("b2b_ready", lif.load_ready, (k == 0 || k >= 8) ? 1 : 0);
      if (frame_done) seen++;
      if (k == 1) lif.load_valid = 1'b0;
      step();
    end
    chk("b2b_frame_done2", frame_done, 1);
    if (frame_done) seen++;
    chk("b2b_end_valid", bit_valid, 0);
    chk("b2b_end_busy", busy, 0);
    step();
    chk("b2b_fd_pulses", seen, 2);

    // 0x1B, LSB first, msb_first toggled mid-frame
    exp8 = 8'b11011000;
    msb_first = 1'b0;
    lif.load_data = 8'h1B;
    lif.load_valid = 1'b1;
    step();
    lif.load_valid = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("lsb_bit", bit_out, exp8[7-i]);
      chk("lsb_valid", bit_valid, 1);
      if (i == 0) msb_first = 1'b1;
      step();
    end
    chk("lsb_frame_done", frame_done, 1);
    step();

    // Offers while hold is full are ignored
    div = 8'd1;
    lif.load_data = 8'h5A;
    lif.load_valid = 1'b1;
    step();
    lif.load_valid = 1'b0;
    step();
    chk("hf_first_valid", bit_valid, 1);
    w1 = {7'b0, bit_out};
    lif.load_data = 8'h3C;
    lif.load_valid = 1'b1;
    step();
    chk("hf_ready_low", lif.load_ready, 0);
    j = 0;
    while (!lif.load_ready && j < 40) begin
      if (bit_valid) w1 = {w1[6:0], bit_out};
      lif.load_data = 8'($urandom);
      lif.load_valid = 1'b1;
      step();
      j++;
    end
    lif.load_valid = 1'b0;
    chk("hf_ready_rise_cycle", j, 15);
    chk("hf_frame_done", frame_done, 1);
    chk("hf_second_start", bit_valid, 1);
    chk("hf_word1", w1, 8'h5A);
    w2 = 8'h00;
    nb = 0;
    j = 0;
    while (nb < 8 && j < 40) begin
      if (bit_valid) begin
        w2 = {w2[6:0], bit_out};
        nb++;
      end
      step();
      j++;
    end
    chk("hf_nbits", nb, 8);
    chk("hf_word2", w2, 8'h3C);
    j = 0;
    while (!frame_done && j < 10) begin
      step();
      j++;
    end
    chk("hf_end_fd", frame_done, 1);
    chk("hf_end_busy", busy, 0);
    step();

    // Reset mid-frame, with a handshake offered during reset
    div = 8'd2;
    lif.load_data = 8'hFF;
    lif.load_valid = 1'b1;
    step();
    lif.load_valid = 1'b0;
    step();
    step();
    step();
    chk("mr_busy_before", busy, 1);
    rst = 1'b1;
    lif.load_data = 8'h55;
    lif.load_valid = 1'b1;
    step();
    step();
    chk("mr_bit_out", bit_out, 0);
    chk("mr_bit_valid", bit_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_frame_done", frame_done, 0);
    chk("mr_load_ready", lif.load_ready, 1);
    rst = 1'b0;
    lif.load_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bit_valid || frame_done || busy) seen++;
    end
    chk("mr_quiet_after", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
